// File: rtl/lm_sm_sequencer.sv
// Load-Multiple / Store-Multiple sequencer: walks a register mask lowest-first and
// moves one word per selected register between the register file and data memory.
//
// state | meaning
// IDLE  | waiting for start; memory held in harmless read
// XFER  | SM: write R[idx] to mem; LM: issue read of mem[addr_q]
// LM_WB | LM only: write registered read data into R[idx]
// DONE  | one-cycle completion pulse, last_addr valid
module lm_sm_sequencer #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 16,
  parameter int NUM_REGS = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              op_sm,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [NUM_REGS-1:0] reg_mask,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] last_addr,
  output logic              mem_rwbar,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic [2:0]        rf_rd_addr,
  input  logic [DATA_W-1:0] rf_rd_data,
  output logic              rf_wr_en,
  output logic [2:0]        rf_wr_addr,
  output logic [DATA_W-1:0] rf_wr_data
);

  typedef enum logic [1:0] {IDLE, XFER, LM_WB, DONE} state_t;

  state_t              state, state_nxt;
  logic                op_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [ADDR_W-1:0]   mem_addr_hold;
  logic [NUM_REGS-1:0] mask_q;
  logic [NUM_REGS-1:0] mask_rest;
  logic [2:0]          idx;
  logic                advance;

  always_comb begin
    idx = '0;
    for (int i = NUM_REGS - 1; i >= 0; i--) begin
      if (mask_q[i]) idx = i[2:0];
    end
  end

  // clearing the lowest set bit is the same as clearing mask_q[idx]
  assign mask_rest = mask_q & (mask_q - 1'b1);
  assign advance   = ((state == XFER) && op_q) || (state == LM_WB);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= IDLE;
      op_q          <= 1'b0;
      addr_q        <= '0;
      mask_q        <= '0;
      mem_addr_hold <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        op_q   <= op_sm;
        addr_q <= base_addr;
        mask_q <= reg_mask;
      end
      if (state == XFER) mem_addr_hold <= addr_q;
      if (advance) begin
        mask_q <= mask_rest;
        addr_q <= addr_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    mem_rwbar = 1'b1;
    rf_wr_en  = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = (reg_mask != '0) ? XFER : DONE;
      end
      XFER: begin
        if (op_q) begin
          mem_rwbar = 1'b0;
          state_nxt = (mask_rest != '0) ? XFER : DONE;
        end else begin
          state_nxt = LM_WB;
        end
      end
      LM_WB: begin
        rf_wr_en  = 1'b1;
        state_nxt = (mask_rest != '0) ? XFER : DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // outside XFER the address bus keeps the last address actually accessed
  assign mem_addr       = (state == XFER) ? addr_q : mem_addr_hold;
  assign mem_write_data = rf_rd_data;
  assign rf_rd_addr     = idx;
  assign rf_wr_addr     = idx;
  assign rf_wr_data     = mem_read_data;
  assign last_addr      = addr_q;

endmodule

// File: tb/tb_lm_sm_sequencer.sv
// Directed bench for lm_sm_sequencer with a behavioural memory and register file.
module tb_lm_sm_sequencer;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic        op_sm = 1'b0;
  logic [15:0] base_addr = '0;
  logic [7:0]  reg_mask = '0;
  logic        busy, done, mem_rwbar, rf_wr_en;
  logic [15:0] last_addr, mem_addr, mem_write_data, mem_read_data, rf_rd_data, rf_wr_data;
  logic [2:0]  rf_rd_addr, rf_wr_addr;

  logic [15:0] mem [0:65535];
  logic [15:0] regs [0:7];
  int          mem_wr_cnt = 0;
  int          rf_wr_cnt = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  lm_sm_sequencer dut (
    .clk(clk), .resetn(resetn), .start(start), .op_sm(op_sm),
    .base_addr(base_addr), .reg_mask(reg_mask), .busy(busy), .done(done),
    .last_addr(last_addr), .mem_rwbar(mem_rwbar), .mem_addr(mem_addr),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
    .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data), .rf_wr_en(rf_wr_en),
    .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data)
  );

  always @(posedge clk) begin
    if (mem_rwbar) mem_read_data <= mem[mem_addr];
    else begin
      mem[mem_addr] <= mem_write_data;
      mem_wr_cnt    <= mem_wr_cnt + 1;
    end
  end

  assign rf_rd_data = regs[rf_rd_addr];

  always @(posedge clk) begin
    if (rf_wr_en) begin
      regs[rf_wr_addr] <= rf_wr_data;
      rf_wr_cnt        <= rf_wr_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // returns at the negedge just after the accepting edge (cycle 1)
  task automatic pulse_start(input logic sm, input logic [15:0] base, input logic [7:0] mask);
    @(negedge clk);
    op_sm = sm; base_addr = base; reg_mask = mask; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    logic [15:0] ea;
    int          wc;
    for (int i = 0; i < 8; i++) regs[i] = 16'h0000;
    mem_read_data = '0;

    // reset values
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_last_addr", last_addr, 0);
    chk("rst_rwbar", mem_rwbar, 1);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_rf_wr_en", rf_wr_en, 0);
    chk("rst_rf_rd_addr", rf_rd_addr, 0);
    chk("rst_rf_wr_addr", rf_wr_addr, 0);
    @(negedge clk);
    resetn = 1'b1;

    // SM mask 0x05 base 0x0004
    regs[0] = 16'h1111; regs[2] = 16'h2222;
    pulse_start(1'b1, 16'h0004, 8'h05);
    chk("sm5_c1_rwbar", mem_rwbar, 0);
    chk("sm5_c1_addr", mem_addr, 16'h0004);
    chk("sm5_c1_wdata", mem_write_data, 16'h1111);
    chk("sm5_c1_busy", busy, 1);
    @(negedge clk);
    chk("sm5_c2_rwbar", mem_rwbar, 0);
    chk("sm5_c2_addr", mem_addr, 16'h0005);
    chk("sm5_c2_wdata", mem_write_data, 16'h2222);
    @(negedge clk);
    chk("sm5_c3_done", done, 1);
    chk("sm5_c3_busy", busy, 1);
    chk("sm5_c3_last", last_addr, 16'h0006);
    chk("sm5_c3_rwbar", mem_rwbar, 1);
    @(negedge clk);
    chk("sm5_c4_busy", busy, 0);
    chk("sm5_c4_done", done, 0);
    chk("sm5_mem4", mem[16'h0004], 16'h1111);
    chk("sm5_mem5", mem[16'h0005], 16'h2222);

    // LM mask 0x81 base 0x000A
    mem[16'h000A] = 16'hBEEF; mem[16'h000B] = 16'hCAFE;
    pulse_start(1'b0, 16'h000A, 8'h81);
    chk("lm_c1_rwbar", mem_rwbar, 1);
    chk("lm_c1_addr", mem_addr, 16'h000A);
    chk("lm_c1_wr_en", rf_wr_en, 0);
    @(negedge clk);
    chk("lm_c2_wr_en", rf_wr_en, 1);
    chk("lm_c2_wr_addr", rf_wr_addr, 0);
    chk("lm_c2_wr_data", rf_wr_data, 16'hBEEF);
    @(negedge clk);
    chk("lm_c3_wr_en", rf_wr_en, 0);
    chk("lm_c3_addr", mem_addr, 16'h000B);
    @(negedge clk);
    chk("lm_c4_wr_en", rf_wr_en, 1);
    chk("lm_c4_wr_addr", rf_wr_addr, 7);
    chk("lm_c4_wr_data", rf_wr_data, 16'hCAFE);
    @(negedge clk);
    chk("lm_c5_done", done, 1);
    chk("lm_c5_last", last_addr, 16'h000C);
    chk("lm_r0", regs[0], 16'hBEEF);
    chk("lm_r7", regs[7], 16'hCAFE);

    // empty mask
    @(negedge clk);
    wc = mem_wr_cnt;
    pulse_start(1'b1, 16'h1234, 8'h00);
    chk("empty_done", done, 1);
    chk("empty_last", last_addr, 16'h1234);
    chk("empty_rwbar", mem_rwbar, 1);
    @(negedge clk);
    chk("empty_done_gone", done, 0);
    chk("empty_no_write", mem_wr_cnt, wc);

    // SM mask 0xFF base 0xFFFE with wrap, plus an ignored second start
    for (int i = 0; i < 8; i++) regs[i] = 16'hA000 + 16'(i);
    mem[16'h5000] = 16'h7777;
    pulse_start(1'b1, 16'hFFFE, 8'hFF);
    ea = 16'hFFFE;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("smff_addr%0d", i), mem_addr, ea);
      chk($sformatf("smff_wdata%0d", i), mem_write_data, 16'hA000 + 16'(i));
      if (i == 2) begin
        base_addr = 16'h5000; reg_mask = 8'h01; start = 1'b1;
      end
      if (i == 3) start = 1'b0;
      ea = ea + 16'h0001;
      @(negedge clk);
    end
    chk("smff_done", done, 1);
    chk("smff_last", last_addr, 16'h0006);
    @(negedge clk);
    chk("smff_idle", busy, 0);
    chk("smff_mem_ffff", mem[16'hFFFF], 16'hA001);
    chk("smff_mem_0005", mem[16'h0005], 16'hA007);
    chk("smff_mem_5000", mem[16'h5000], 16'h7777);

    // reset during LM_WB
    regs[0] = 16'h0BAD;
    mem[16'h0020] = 16'h5555; mem[16'h0021] = 16'h6666;
    wc = rf_wr_cnt;
    pulse_start(1'b0, 16'h0020, 8'h03);
    @(negedge clk);
    chk("rstmid_in_wb", rf_wr_en, 1);
    #2 resetn = 1'b0;
    #1;
    chk("rstmid_wr_en", rf_wr_en, 0);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_rwbar", mem_rwbar, 1);
    chk("rstmid_mem_addr", mem_addr, 0);
    @(negedge clk);
    resetn = 1'b1;
    chk("rstmid_no_rf_write", rf_wr_cnt, wc);
    chk("rstmid_r0_kept", regs[0], 16'h0BAD);
    regs[1] = 16'h4321;
    pulse_start(1'b1, 16'h0030, 8'h02);
    chk("post_rst_rwbar", mem_rwbar, 0);
    chk("post_rst_addr", mem_addr, 16'h0030);
    @(negedge clk);
    chk("post_rst_done", done, 1);
    chk("post_rst_last", last_addr, 16'h0031);
    chk("post_rst_mem", mem[16'h0030], 16'h4321);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lm_sm_sequencer.md
Name: lm_sm_sequencer

Overview:
- Initiator-side controller for the single-port data memory. Executes IITB-RISC Load-Multiple (LM) and Store-Multiple (SM) transfers.
- Walks an 8-bit register mask in ascending order and issues one memory access per selected register at consecutive addresses.
- Moves data between the register file and memory, then signals completion to the core control FSM.
- Sits between the datapath controller, the register file and the memory.

Parameters:
- DATA_W, 16, data word width (memory and register file)
- ADDR_W, 16, memory address width
- NUM_REGS, 8, register count; mask width; index width = 3

Ports:
- clk  input  1  clock, all state changes on posedge
- resetn  input  1  asynchronous active-low reset
- start  input  1  one-cycle request; sampled only in IDLE
- op_sm  input  1  1 = SM (register->memory), 0 = LM (memory->register)
- base_addr  input  ADDR_W  address of first transferred word
- reg_mask  input  NUM_REGS  bit i set = transfer Ri
- busy  output  1  high from the cycle after an accepted start through the DONE cycle
- done  output  1  one-cycle completion pulse
- last_addr  output  ADDR_W  base_addr + number of transferred words (mod 2^ADDR_W), valid when done=1
- mem_rwbar  output  1  1 = read, 0 = write; sampled by memory at posedge
- mem_addr  output  ADDR_W  memory address
- mem_write_data  output  DATA_W  write data to memory
- mem_read_data  input  DATA_W  memory read data, registered by memory at the posedge where rwbar=1
- rf_rd_addr  output  3  register file read index (SM)
- rf_rd_data  input  DATA_W  combinational register file read data
- rf_wr_en  output  1  register file write enable
- rf_wr_addr  output  3  register file write index
- rf_wr_data  output  DATA_W  register file write data

Behaviour:
- Reset, asynchronous active-low resetn; clock clk. Reset forces state=IDLE and clears all internal registers. Output values in reset: busy=0, done=0, last_addr=0, mem_rwbar=1, mem_addr=0, rf_wr_en=0, rf_rd_addr=0, rf_wr_addr=0.
- States: IDLE, XFER, LM_WB, DONE.
- IDLE:
  - mem_rwbar=1 (harmless read); rf_wr_en=0.
  - On start=1, capture op_sm, base_addr into addr_q, reg_mask into mask_q, and clear count.
  - Next state = XFER if reg_mask != 0, else DONE.
- Current index = lowest set bit of mask_q.
- XFER, SM:
  - Drive mem_rwbar=0, mem_addr=addr_q, rf_rd_addr=idx, and mem_write_data=rf_rd_data (combinational pass-through). The memory writes at the closing edge.
  - At that edge, clear mask_q[idx] and increment addr_q and count.
  - Next state = DONE if no bits remain, else XFER. Cost: 1 cycle per register.
- XFER, LM:
  - Drive mem_rwbar=1 and mem_addr=addr_q. The memory registers read data at the closing edge. Next state = LM_WB.
- LM_WB:
  - Drive rf_wr_en=1, rf_wr_addr=idx, rf_wr_data=mem_read_data, mem_rwbar=1.
  - Clear mask_q[idx] and increment addr_q and count.
  - Next state = DONE if no bits remain, else XFER. Cost: 2 cycles per register.
- DONE: done=1, busy=1, last_addr=addr_q, mem_rwbar=1. Next state = IDLE.
- mem_rwbar=0 occurs only in XFER with SM. rf_wr_en=1 occurs only in LM_WB.
- mem_addr is meaningful only in XFER; otherwise it holds its last value.
- addr_q increments wrap 0xFFFF -> 0x0000.
- start asserted while not IDLE is ignored; the new mask and base are not captured.
- Empty mask: no memory write and no rf write; done pulses in the cycle after start.
- resetn low mid-transfer: abort immediately. No further writes to memory or register file; outputs return to reset values.
- Total latency from the start edge to done high:
  - SM: popcount(mask) + 1 cycles.
  - LM: 2*popcount(mask) + 1 cycles.

Test Plan:
- Reset mid-LM (assert resetn=0 during LM_WB) -> rf_wr_en drops asynchronously, busy=0, mem_rwbar=1, and a following start runs normally.
- SM, mask=0x05, base=0x0004, R0=0x1111, R2=0x2222 -> cycle1 write 0x1111 @0x0004; cycle2 write 0x2222 @0x0005; cycle3 done=1, last_addr=0x0006.
- LM, mask=0x81, base=0x000A, mem[0xA]=0xBEEF, mem[0xB]=0xCAFE -> R0=0xBEEF (cycle2), R7=0xCAFE (cycle4), done in cycle5, last_addr=0x000C.
- Empty mask=0x00 with op_sm=1 -> no mem_rwbar=0 cycle, done=1 one cycle after start, last_addr=base.
- SM, mask=0xFF, base=0xFFFE -> writes at 0xFFFE, 0xFFFF, 0x0000..0x0005; last_addr=0x0006; a second start pulse mid-transfer is ignored.
